// File: rtl/lm80c_mem_wr_arbiter.sv
// rtl/lm80c_mem_wr_arbiter.sv - write-port arbiter for the ROM/RAM DPRAMs
//
// Purpose: the only writer of the 32 KB ROM and 64 KB RAM DPRAMs. The downloader,
// the eraser and the Z80 each own a one-deep pending slot. A fixed priority
// (dl > er > cpu) picks one slot per cycle. An aging counter forces a CPU
// grant after CPU_MAX_WAIT pass-overs. The grant is decoded into a registered
// ROM or RAM write.
//
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   dl_wr/dl_addr/dl_data      downloader byte write (25-bit space)
//   er_wr/er_addr/er_data      eraser byte write (25-bit space)
//   cpu_wr/cpu_addr/cpu_data   Z80 byte write (16-bit space)
//   rom_enabled                1 = ROM mapped at 0000-7FFF, CPU writes there are blocked
//   cpu_busy                   CPU slot occupied
//   rom_wr/rom_addr/rom_data   registered ROM write port
//   ram_wr/ram_addr/ram_data   registered RAM write port
//   ovf                        sticky {cpu,er,dl}: request lost to a full slot
//   dec_err                    sticky: dl/er address decoded to neither memory

module lm80c_mem_wr_arbiter #(
   parameter int CPU_MAX_WAIT = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        dl_wr,
   input  logic [24:0] dl_addr,
   input  logic [7:0]  dl_data,
   input  logic        er_wr,
   input  logic [24:0] er_addr,
   input  logic [7:0]  er_data,
   input  logic        cpu_wr,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_data,
   input  logic        rom_enabled,
   output logic        cpu_busy,
   output logic        rom_wr,
   output logic [14:0] rom_addr,
   output logic [7:0]  rom_data,
   output logic        ram_wr,
   output logic [15:0] ram_addr,
   output logic [7:0]  ram_data,
   output logic [2:0]  ovf,
   output logic        dec_err
);

   localparam int AW = (CPU_MAX_WAIT < 1) ? 1 : $clog2(CPU_MAX_WAIT + 1);
   localparam logic [AW-1:0] AGE_MAX = AW'(CPU_MAX_WAIT);

   // pending slots
   logic        dl_v_q, er_v_q, cpu_v_q;
   logic [24:0] dl_addr_q, er_addr_q;
   logic [15:0] cpu_addr_q;
   logic [7:0]  dl_data_q, er_data_q, cpu_data_q;
   logic [AW-1:0] age_q;
   logic [2:0]  ovf_q;
   logic        dec_err_q;

   // grant and decode
   logic        cpu_force;
   logic        gnt_dl, gnt_er, gnt_cpu, gnt_ext;
   logic [24:0] sel_addr;
   logic [7:0]  sel_data;
   logic        ext_rom, ext_ram;
   logic        nxt_rom_wr, nxt_ram_wr, nxt_dec_err;
   logic [15:0] nxt_ram_addr;
   logic [7:0]  nxt_ram_data;

   always_comb begin
      cpu_force = 1'b0;
      if (CPU_MAX_WAIT != 0)
         cpu_force = cpu_v_q && (age_q == AGE_MAX);
      gnt_dl  = dl_v_q && !cpu_force;
      gnt_er  = er_v_q && !dl_v_q && !cpu_force;
      gnt_cpu = cpu_v_q && (cpu_force || (!dl_v_q && !er_v_q));
      gnt_ext = gnt_dl || gnt_er;
   end

   always_comb begin
      sel_addr = gnt_dl ? dl_addr_q : er_addr_q;
      sel_data = gnt_dl ? dl_data_q : er_data_q;
      ext_rom  = sel_addr < 25'h0008000;
      ext_ram  = sel_addr[24:16] == 9'd1;

      nxt_rom_wr  = gnt_ext && ext_rom;
      // CPU writes into the mapped ROM window are silently discarded
      nxt_ram_wr  = (gnt_ext && ext_ram) ||
                    (gnt_cpu && !(rom_enabled && !cpu_addr_q[15]));
      nxt_dec_err = gnt_ext && !ext_rom && !ext_ram;

      nxt_ram_addr = gnt_cpu ? cpu_addr_q : sel_addr[15:0];
      nxt_ram_data = gnt_cpu ? cpu_data_q : sel_data;
   end

   // Slot capture. A strobe may refill a slot in the same cycle it is granted.
   // A strobe that hits a slot still waiting is dropped and flagged.
   always_ff @(posedge clk) begin
      if (reset) begin
         dl_v_q     <= 1'b0;
         er_v_q     <= 1'b0;
         cpu_v_q    <= 1'b0;
         dl_addr_q  <= '0;
         er_addr_q  <= '0;
         cpu_addr_q <= '0;
         dl_data_q  <= '0;
         er_data_q  <= '0;
         cpu_data_q <= '0;
         ovf_q      <= '0;
      end else begin
         if (dl_wr) begin
            if (!dl_v_q || gnt_dl) begin
               dl_v_q    <= 1'b1;
               dl_addr_q <= dl_addr;
               dl_data_q <= dl_data;
            end else begin
               ovf_q[0] <= 1'b1;
            end
         end else if (gnt_dl) begin
            dl_v_q <= 1'b0;
         end

         if (er_wr) begin
            if (!er_v_q || gnt_er) begin
               er_v_q    <= 1'b1;
               er_addr_q <= er_addr;
               er_data_q <= er_data;
            end else begin
               ovf_q[1] <= 1'b1;
            end
         end else if (gnt_er) begin
            er_v_q <= 1'b0;
         end

         if (cpu_wr) begin
            if (!cpu_v_q || gnt_cpu) begin
               cpu_v_q    <= 1'b1;
               cpu_addr_q <= cpu_addr;
               cpu_data_q <= cpu_data;
            end else begin
               ovf_q[2] <= 1'b1;
            end
         end else if (gnt_cpu) begin
            cpu_v_q <= 1'b0;
         end
      end
   end

   // CPU aging: counts pass-overs while the CPU waits, saturating at the limit
   always_ff @(posedge clk) begin
      if (reset)
         age_q <= '0;
      else if (gnt_cpu)
         age_q <= '0;
      else if (cpu_v_q && (age_q != AGE_MAX))
         age_q <= age_q + AW'(1);
   end

   // Registered write port. Address/data only move when a write is issued.
   always_ff @(posedge clk) begin
      if (reset) begin
         rom_wr    <= 1'b0;
         rom_addr  <= '0;
         rom_data  <= '0;
         ram_wr    <= 1'b0;
         ram_addr  <= '0;
         ram_data  <= '0;
         dec_err_q <= 1'b0;
      end else begin
         rom_wr <= nxt_rom_wr;
         ram_wr <= nxt_ram_wr;
         if (nxt_rom_wr) begin
            rom_addr <= sel_addr[14:0];
            rom_data <= sel_data;
         end
         if (nxt_ram_wr) begin
            ram_addr <= nxt_ram_addr;
            ram_data <= nxt_ram_data;
         end
         if (nxt_dec_err)
            dec_err_q <= 1'b1;
      end
   end

   assign cpu_busy = cpu_v_q;
   assign ovf      = ovf_q;
   assign dec_err  = dec_err_q;

endmodule
